data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter S_INDEX, default 3, meaning index bits (2**S_INDEX sets, direct-mapped); line fixed at 32 bytes (offset bits 4:0).
REQ-002 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have mem_read  input  1  CPU load request.
REQ-005 SHALL have mem_write  input  1  CPU store request.
REQ-006 SHALL have mem_byte_enable  input  4  store byte lanes.
REQ-007 SHALL have mem_address  input  32  CPU byte address; bits 1:0 ignored.
REQ-008 SHALL have mem_wdata  input  32  store data.
REQ-009 SHALL have mem_rdata  output  32  load data.
REQ-010 SHALL have mem_resp  output  1  request-complete pulse.
REQ-011 SHALL have pmem_read, pmem_write  output  1 each  line fill / writeback strobes.
REQ-012 SHALL have pmem_address  output  32  line-aligned address (bits 4:0 zero).
REQ-013 SHALL have pmem_wdata  output  256  / pmem_rdata  input  256  line data.
REQ-014 SHALL have pmem_resp  input  1  memory-side completion.

Function
REQ-015 SHALL decode address as tag [31:5+S_INDEX], index [4+S_INDEX:5], word [4:2].
REQ-016 SHALL use FSM states IDLE, WRITEBACK, ALLOCATE.
REQ-017 IDLE read hit (valid and tag match) SHALL assert mem_resp combinationally same cycle with mem_rdata = selected word; zero-cycle hit latency.
REQ-018 IDLE write hit SHALL assert mem_resp same cycle, write enabled bytes of the selected word at the clock edge, set dirty.
REQ-019 IDLE miss with clean/invalid victim SHALL go to ALLOCATE; dirty victim SHALL go to WRITEBACK.
REQ-020 WRITEBACK SHALL hold pmem_write=1, pmem_address={victim tag,index,5'b0}, pmem_wdata=victim line until pmem_resp; on pmem_resp go to ALLOCATE.
REQ-021 ALLOCATE SHALL hold pmem_read=1, pmem_address={req tag,index,5'b0} until pmem_resp; on pmem_resp write line, tag, valid=1, dirty=0, return IDLE.
REQ-022 After fill, the retried request SHALL hit in IDLE the following cycle; miss latency = fill cycles + 1 (+ writeback cycles if dirty).
REQ-023 mem_resp SHALL pulse exactly one cycle per request and never outside IDLE; CPU holds request stable until mem_resp.
REQ-024 No request (read=write=0) SHALL produce no state change and mem_resp=0.
REQ-025 mem_read and mem_write both high SHALL be treated as write.
REQ-026 pmem_read and pmem_write SHALL never be asserted together.
REQ-027 mem_rdata SHALL be don't-care when mem_resp=0 or on writes.

Reset
REQ-028 rst sampled high SHALL clear all valid and dirty bits, force IDLE, and drive mem_resp=0, pmem_read=0, pmem_write=0 from the following cycle.
REQ-029 rst during WRITEBACK/ALLOCATE SHALL abandon the transaction; late pmem_resp after reset SHALL be ignored.
REQ-030 Data and tag arrays SHALL need no reset.

Configuration
REQ-031 Macro DCACHE_STATS_EN defined SHALL add outputs hit_count and miss_count (32-bit each, saturating, reset 0); count once per request at IDLE decision (a miss counted once, not its retry hit).
REQ-032 Macro undefined SHALL omit those ports and counters; functional behaviour identical.

Structure
REQ-033 Package cache_types SHALL hold dcache_state_t enum, line_t (256-bit), and offset/index/tag width constants derived from S_INDEX.
REQ-034 Sub-module cache_array SHALL implement a parameterised flop array with write enable and async read, instantiated for data (with 32-byte enable), tag, valid, dirty.

Verification
REQ-035 After reset, read 0x0000_0040 -> pmem_read with pmem_address 0x0000_0040; pmem_resp with line word0=0xDEADBEEF -> next cycle mem_resp=1, mem_rdata=0xDEADBEEF.
REQ-036 Write 0x0000_0044, byte_enable 4'b0011, wdata 0x1234_5678 on filled line -> same-cycle mem_resp; subsequent read 0x44 returns upper bytes unchanged, low half 0x5678.
REQ-037 Dirty line at index 2 then read conflicting 0x0000_0140 (S_INDEX=3) -> pmem_write to 0x0000_0040 with modified line, then pmem_read to 0x0000_0140.
REQ-038 rst asserted mid-ALLOCATE -> strobes low next cycle; prior-hit address 0x40 now misses.
REQ-039 With DCACHE_STATS_EN: 1 miss + 3 hits -> miss_count=1, hit_count=3; pmem_read/pmem_write never simultaneously high throughout.

Source files
------------

// File: rtl/data_cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_types: shared types and width constants for the direct-mapped data cache.
//   dcache_state_t : controller states (IDLE / WRITEBACK / ALLOCATE)
//   line_t         : one 32-byte cache line
//   OFFSET_W etc.  : fixed address-field widths; index/tag widths are functions
//                    of the cache's S_INDEX parameter (index_w / tag_w).
// -----------------------------------------------------------------------------
package cache_types;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int LINE_BYTES = 32;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int OFFSET_W   = 5;              // byte offset inside a line
    localparam int WSEL_W     = 3;              // word select, address [4:2]
    localparam int DEF_S_INDEX = 3;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } dcache_state_t;

    function automatic int index_w(input int s_index);
        return s_index;
    endfunction

    function automatic int tag_w(input int s_index);
        return ADDR_W - OFFSET_W - s_index;
    endfunction

    localparam int DEF_TAG_W = tag_w(DEF_S_INDEX);

endpackage

// File: rtl/data_cache_array.sv
// -----------------------------------------------------------------------------
// cache_array: 2**S_DEPTH x WIDTH flop array, asynchronous read, lane-wise
// write enable (BE_W lanes of WIDTH/BE_W bits). HAS_RST=1 clears the whole
// array on a synchronous active-high rst (used for valid/dirty bits); data and
// tag instances leave HAS_RST=0 so they carry no reset logic.
// Ports:
//   clk, rst       clock, synchronous active-high reset (only if HAS_RST)
//   i_we[BE_W]     per-lane write enable at the rising edge
//   i_idx          row address shared by read and write
//   i_wdata        write data
//   o_rdata        combinational read of row i_idx
// -----------------------------------------------------------------------------
module cache_array #(
    parameter int WIDTH   = 1,
    parameter int S_DEPTH = 3,
    parameter int BE_W    = 1,
    parameter bit HAS_RST = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BE_W-1:0]    i_we,
    input  logic [S_DEPTH-1:0] i_idx,
    input  logic [WIDTH-1:0]   i_wdata,
    output logic [WIDTH-1:0]   o_rdata
);

    localparam int DEPTH  = 1 << S_DEPTH;
    localparam int LANE_W = WIDTH / BE_W;

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (HAS_RST && rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_we[b]) begin
                    r_mem[i_idx][b*LANE_W +: LANE_W] <= i_wdata[b*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache: direct-mapped, write-back, write-allocate data cache with 32-byte
// lines and 2**S_INDEX sets. Hits complete in the request cycle (zero latency);
// misses write back a dirty victim, fill the line, then the held request hits.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_read/mem_write       CPU request (both high = write), held until mem_resp
//   mem_byte_enable[4]       store byte lanes
//   mem_address[32]          CPU byte address (bits 1:0 ignored)
//   mem_wdata/mem_rdata[32]  store / load data
//   mem_resp                 one-cycle request-complete pulse (IDLE only)
//   pmem_read/pmem_write     line fill / writeback strobes, held until pmem_resp
//   pmem_address[32]         line-aligned memory address
//   pmem_wdata/pmem_rdata    256-bit line data
//   pmem_resp                memory-side completion
// Optional (macro DCACHE_STATS_EN): hit_count, miss_count saturating counters,
// one count per request decided in IDLE.
// -----------------------------------------------------------------------------
module data_cache
    import cache_types::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int TAG_W = tag_w(S_INDEX);
    localparam int IDX_W = index_w(S_INDEX);

    // ---- address decode ----------------------------------------------------
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [WSEL_W-1:0] w_word;
    logic              w_unused_addr;

    assign w_tag  = mem_address[ADDR_W-1 -: TAG_W];
    assign w_idx  = mem_address[OFFSET_W +: IDX_W];
    assign w_word = mem_address[OFFSET_W-1:2];
    assign w_unused_addr = &{1'b0, mem_address[1:0]};

    // ---- array read ports --------------------------------------------------
    line_t            w_line_rd;
    logic [TAG_W-1:0] w_tag_rd;
    logic             w_valid_rd;
    logic             w_dirty_rd;

    // ---- control -----------------------------------------------------------
    dcache_state_t r_state;
    logic          r_pmem_read;
    logic          r_pmem_write;

    logic w_req;
    logic w_hit;
    logic w_idle_hit;
    logic w_idle_miss;
    logic w_wr_hit;
    logic w_fill;

    assign w_req       = mem_read | mem_write;
    assign w_hit       = w_valid_rd & (w_tag_rd == w_tag);
    assign w_idle_hit  = (r_state == IDLE) & w_req & w_hit;
    assign w_idle_miss = (r_state == IDLE) & w_req & ~w_hit;
    // mem_write dominates, so read+write is a store.
    assign w_wr_hit    = w_idle_hit & mem_write & ~rst;
    // Fill only while a fill is actually outstanding; a stale pmem_resp seen
    // after a reset lands in IDLE and is dropped here.
    assign w_fill      = (r_state == ALLOCATE) & pmem_resp & ~rst;

    assign mem_resp  = w_idle_hit;
    assign mem_rdata = w_line_rd[{w_word, 5'b0} +: WORD_W];

    // ---- array write ports -------------------------------------------------
    logic [LINE_BYTES-1:0] w_data_we;
    line_t                 w_data_wdata;

    always_comb begin
        w_data_we    = '0;
        w_data_wdata = {(LINE_W/WORD_W){mem_wdata}};
        if (w_fill) begin
            w_data_we    = '1;
            w_data_wdata = pmem_rdata;
        end else if (w_wr_hit) begin
            w_data_we[{w_word, 2'b0} +: 4] = mem_byte_enable;
        end
    end

    cache_array #(.WIDTH(LINE_W), .S_DEPTH(IDX_W), .BE_W(LINE_BYTES), .HAS_RST(1'b0)) u_data (
        .clk     (clk),
        .rst     (1'b0),
        .i_we    (w_data_we),
        .i_idx   (w_idx),
        .i_wdata (w_data_wdata),
        .o_rdata (w_line_rd)
    );

    cache_array #(.WIDTH(TAG_W), .S_DEPTH(IDX_W), .BE_W(1), .HAS_RST(1'b0)) u_tag (
        .clk     (clk),
        .rst     (1'b0),
        .i_we    (w_fill),
        .i_idx   (w_idx),
        .i_wdata (w_tag),
        .o_rdata (w_tag_rd)
    );

    cache_array #(.WIDTH(1), .S_DEPTH(IDX_W), .BE_W(1), .HAS_RST(1'b1)) u_valid (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_fill),
        .i_idx   (w_idx),
        .i_wdata (1'b1),
        .o_rdata (w_valid_rd)
    );

    // Store hit sets dirty; a fill installs a clean line.
    cache_array #(.WIDTH(1), .S_DEPTH(IDX_W), .BE_W(1), .HAS_RST(1'b1)) u_dirty (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_fill | w_wr_hit),
        .i_idx   (w_idx),
        .i_wdata (w_wr_hit),
        .o_rdata (w_dirty_rd)
    );

    // ---- controller FSM (strobes registered with the state) ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_idle_miss) begin
                        if (w_valid_rd && w_dirty_rd) begin
                            r_state      <= WRITEBACK;
                            r_pmem_write <= 1'b1;
                        end else begin
                            r_state      <= ALLOCATE;
                            r_pmem_read  <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        r_state      <= ALLOCATE;
                        r_pmem_write <= 1'b0;
                        r_pmem_read  <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        r_state     <= IDLE;
                        r_pmem_read <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read  = r_pmem_read;
    assign pmem_write = r_pmem_write;
    assign pmem_wdata = w_line_rd;

    // Victim address during writeback, requested line otherwise.
    always_comb begin
        if (r_state == WRITEBACK) begin
            pmem_address = {w_tag_rd, w_idx, {OFFSET_W{1'b0}}};
        end else begin
            pmem_address = {w_tag, w_idx, {OFFSET_W{1'b0}}};
        end
    end

`ifdef DCACHE_STATS_EN
    // ---- statistics --------------------------------------------------------
    // r_retry marks that the next hit is the replay of a request already
    // counted as a miss, so it must not also count as a hit.
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic        r_retry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_retry      <= 1'b0;
        end else begin
            if (w_idle_hit) begin
                r_retry <= 1'b0;
                if (!r_retry && r_hit_count != '1) begin
                    r_hit_count <= r_hit_count + 32'd1;
                end
            end
            if (w_idle_miss) begin
                r_retry <= 1'b1;
                if (r_miss_count != '1) begin
                    r_miss_count <= r_miss_count + 32'd1;
                end
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    localparam int S_INDEX = 3;
    localparam int NSETS   = 1 << S_INDEX;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [3:0]   mem_byte_enable = 4'h0;
    logic [31:0]  mem_address = '0;
    logic [31:0]  mem_wdata = '0;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    data_cache #(.S_INDEX(S_INDEX)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Backing memory (line number -> line) and a set-level model of what the
    // cache holds: resident line number, dirty flag and the CPU-visible bytes.
    logic [255:0] bmem [int unsigned];
    bit           m_valid [NSETS];
    bit           m_dirty [NSETS];
    int unsigned  m_line  [NSETS];
    logic [255:0] m_data  [NSETS];

    function automatic logic [255:0] init_line(input int unsigned la);
        logic [255:0] l;
        logic [31:0]  v;
        for (int w = 0; w < 8; w++) begin
            v = (la * 32 + w * 4) ^ 32'h9E37_79B9;
            l[w*32 +: 32] = v;
        end
        return l;
    endfunction

    function automatic logic [255:0] get_line(input int unsigned la);
        if (bmem.exists(la)) return bmem[la];
        return init_line(la);
    endfunction

    task automatic model_invalidate();
        for (int s = 0; s < NSETS; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_invalidate();
    endtask

    // One CPU request, acting as memory with random latency. Returns load data
    // and the cycle in which mem_resp arrived (0 = same-cycle hit).
    task automatic do_req(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          output logic [31:0] rdata_o, output int resp_cyc);
        int unsigned la, set, word;
        bit   hit, exp_wb, done, overlap, rd_seen, wb_seen;
        int   exp_cyc, cyc, lat;
        logic [31:0] exp_rd;
        la   = addr >> 5;
        set  = la % NSETS;
        word = (addr >> 2) & 7;
        hit    = m_valid[set] && (m_line[set] == la);
        exp_wb = !hit && m_valid[set] && m_dirty[set];
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_byte_enable = be; mem_wdata = wd;
        exp_cyc = hit ? 0 : 1;
        cyc = 0; lat = -1; done = 0; overlap = 0; rd_seen = 0; wb_seen = 0;
        rdata_o = 'x; resp_cyc = -1;
        while (!done && cyc < 100) begin
            #1;
            if (pmem_read && pmem_write) overlap = 1;
            if (mem_resp) begin
                done = 1; rdata_o = mem_rdata; resp_cyc = cyc;
            end else if (pmem_read || pmem_write) begin
                if (lat < 0) begin
                    lat = $urandom_range(0, 3);
                    exp_cyc += lat + 1;
                    n_cmp++;
                    if (pmem_write) begin
                        if (wb_seen || rd_seen || !exp_wb || pmem_address !== (m_line[set] << 5)) begin
                            n_err++;
                            $display("FAIL wb_phase: addr %h got pmem_address %h, want writeback=%0d to %h",
                                     addr, pmem_address, exp_wb, m_line[set] << 5);
                        end
                        wb_seen = 1;
                    end else begin
                        if (rd_seen || (exp_wb && !wb_seen) || pmem_address !== (la << 5)) begin
                            n_err++;
                            $display("FAIL fill_phase: addr %h got pmem_address %h want %h (wb_done=%0d)",
                                     addr, pmem_address, la << 5, wb_seen);
                        end
                        rd_seen = 1;
                    end
                end
                if (lat == 0) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        n_cmp++;
                        if (pmem_wdata !== m_data[set]) begin
                            n_err++;
                            $display("FAIL wb_data: got %h want %h", pmem_wdata, m_data[set]);
                        end
                        bmem[m_line[set]] = pmem_wdata;
                    end else begin
                        pmem_rdata = get_line(la);
                    end
                    lat = -1;
                end else begin
                    lat--;
                end
            end
            @(negedge clk);
            pmem_resp = 1'b0;
            cyc++;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: addr %h got no mem_resp in 100 cycles, want one", addr);
            apply_reset();
            return;
        end
        n_cmp++;
        if (resp_cyc != exp_cyc || wb_seen != exp_wb || rd_seen != !hit || overlap) begin
            n_err++;
            $display("FAIL latency: addr %h got resp cycle %0d wb %0d fill %0d overlap %0d, want %0d/%0d/%0d/0",
                     addr, resp_cyc, wb_seen, rd_seen, overlap, exp_cyc, exp_wb, !hit);
        end
        #1;
        n_cmp++;
        if (mem_resp !== 1'b0) begin
            n_err++;
            $display("FAIL resp_pulse: got mem_resp %b with no request, want 0", mem_resp);
        end
        @(negedge clk);
        // Advance the model: install on miss, then apply the access.
        if (!hit) begin
            m_valid[set] = 1'b1; m_line[set] = la; m_dirty[set] = 1'b0;
            m_data[set] = get_line(la);
        end
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_data[set][(word*32 + b*8) +: 8] = wd[b*8 +: 8];
            m_dirty[set] = 1'b1;
        end else begin
            exp_rd = m_data[set][word*32 +: 32];
            n_cmp++;
            if (rdata_o !== exp_rd) begin
                n_err++;
                $display("FAIL load_data: addr %h got %h want %h", addr, rdata_o, exp_rd);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++;
        if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got resp %b rd %b wr %b, want 0 0 0", mem_resp, pmem_read, pmem_write);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [255:0] l;
        logic [31:0]  orig1, rd;
        int           rc;
        l = init_line(2); l[31:0] = 32'hDEAD_BEEF; bmem[2] = l;
        orig1 = l[63:32];
        do_req(0, 1, 32'h0000_0040, 4'h0, 32'h0, rd, rc);
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF || rc < 2) begin
            n_err++; $display("FAIL first_fill: got %h at cycle %0d, want deadbeef after a fill", rd, rc);
        end
        do_req(1, 0, 32'h0000_0044, 4'b0011, 32'h1234_5678, rd, rc);
        n_cmp++;
        if (rc != 0) begin
            n_err++; $display("FAIL write_hit_latency: got %0d want 0", rc);
        end
        do_req(0, 1, 32'h0000_0044, 4'h0, 32'h0, rd, rc);
        n_cmp++;
        if (rd !== {orig1[31:16], 16'h5678}) begin
            n_err++; $display("FAIL partial_write: got %h want %h", rd, {orig1[31:16], 16'h5678});
        end
        do_req(0, 1, 32'h0000_0140, 4'h0, 32'h0, rd, rc);
        n_cmp++;
        if (bmem[2][63:32] !== {orig1[31:16], 16'h5678} || bmem[2][31:0] !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL writeback_line: got %h want %h%h", bmem[2][63:0], {orig1[31:16], 16'h5678}, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_no_request();
        logic [31:0] rd;
        int          rc;
        for (int i = 0; i < 6; i++) begin
            mem_address = $urandom; mem_wdata = $urandom; mem_byte_enable = 4'hF;
            #1;
            n_cmp++;
            if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
                n_err++; $display("FAIL idle_quiet: got resp %b rd %b wr %b want 0 0 0", mem_resp, pmem_read, pmem_write);
            end
            @(negedge clk);
        end
        do_req(0, 1, 32'h0000_0148, 4'h0, 32'h0, rd, rc);
        n_cmp++;
        if (rc != 0) begin
            n_err++; $display("FAIL idle_state_kept: got resp cycle %0d want 0", rc);
        end
    endtask

    task automatic test_both_high();
        logic [31:0] rd, wd;
        int          rc;
        wd = $urandom;
        do_req(1, 1, 32'h0000_015C, 4'hF, wd, rd, rc);
        do_req(0, 1, 32'h0000_015C, 4'h0, 32'h0, rd, rc);
        n_cmp++;
        if (rd !== wd) begin
            n_err++; $display("FAIL read_write_as_write: got %h want %h", rd, wd);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, rd;
        int          kind, rc;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 5) |
                ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            kind = $urandom_range(0, 2);
            do_req(kind != 0, kind != 1, a, 4'($urandom), $urandom, rd, rc);
        end
    endtask

    task automatic test_reset_mid_alloc();
        logic [31:0] rd;
        int          rc;
        bit          seen;
        do_req(0, 1, 32'h0000_0040, 4'h0, 32'h0, rd, rc);
        do_req(0, 1, 32'h0000_0040, 4'h0, 32'h0, rd, rc);
        n_cmp++;
        if (rc != 0) begin
            n_err++; $display("FAIL hit_before_reset: got resp cycle %0d want 0", rc);
        end
        mem_read = 1'b1; mem_address = 32'h0000_02A0; seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            #1;
            if (pmem_read || pmem_write) seen = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL alloc_start: got no memory strobe, want one");
        end
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_invalidate();
        #1;
        n_cmp++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_resp !== 1'b0) begin
            n_err++; $display("FAIL abort_strobes: got rd %b wr %b resp %b want 0 0 0", pmem_read, pmem_write, mem_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = '1;   // stale completion of the abandoned fill
        @(negedge clk);
        pmem_resp = 1'b0;
        do_req(0, 1, 32'h0000_0040, 4'h0, 32'h0, rd, rc);
        n_cmp++;
        if (rc == 0) begin
            n_err++; $display("FAIL miss_after_reset: got resp cycle 0 (hit) want a miss");
        end
        do_req(0, 1, 32'h0000_02A0, 4'h0, 32'h0, rd, rc);
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] rd;
        int          rc;
        apply_reset();
        #1;
        n_cmp++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_err++; $display("FAIL stats_reset: got %0d/%0d want 0/0", hit_count, miss_count);
        end
        @(negedge clk);
        do_req(0, 1, 32'h0000_0060, 4'h0, 32'h0, rd, rc);
        do_req(0, 1, 32'h0000_0060, 4'h0, 32'h0, rd, rc);
        do_req(0, 1, 32'h0000_0064, 4'h0, 32'h0, rd, rc);
        do_req(1, 0, 32'h0000_007C, 4'hF, 32'h0BAD_F00D, rd, rc);
        n_cmp++;
        if (hit_count !== 32'd3 || miss_count !== 32'd1) begin
            n_err++; $display("FAIL stats_counts: got hits %0d misses %0d want 3 1", hit_count, miss_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_no_request();
        test_both_high();
        test_random();
        test_reset_mid_alloc();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
